// File: rtl/uart_tx_feeder.sv
// Byte FIFO and launch sequencer feeding the UART transmit serializer, all in the BRclk domain.
// Optional inter-frame gap state is built only when UART_TX_GAP_EN is defined.
`timescale 1ns/1ps
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                  BRclk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  TX_STATUS,
    output logic                  TX_EN,
    output logic [7:0]            TX_DATA
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3
`ifdef UART_TX_GAP_EN
        , ST_GAP     = 3'd4
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   overflow_q, overflow_d;
    logic                   tx_en_q, tx_en_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   pop_s;
    logic                   push_s;

`ifdef UART_TX_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
`endif

    // Sequencer next state, launch decision and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tx_en_d    = 1'b0;
        tx_data_d  = tx_data_q;
        pop_s      = 1'b0;
        push_s     = 1'b0;
`ifdef UART_TX_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!empty_q && !TX_STATUS) begin
                    pop_s     = 1'b1;
                    tx_en_d   = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = ST_LAUNCH;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (TX_STATUS) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!TX_STATUS) begin
`ifdef UART_TX_GAP_EN
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
`else
                    state_d   = ST_IDLE;
`endif
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
`ifdef UART_TX_GAP_EN
            ST_GAP: begin
                if (gap_cnt_q == GAP_ZERO) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A write while full is accepted only when the same cycle pops a slot free.
        push_s = wr_en && (!full_q || pop_s);

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (wr_en && !push_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == CNT_ZERO);
    end

    // Control and status registers.
    always_ff @(posedge BRclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= 8'h00;
`ifdef UART_TX_GAP_EN
            gap_cnt_q  <= GAP_ZERO;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
`ifdef UART_TX_GAP_EN
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge BRclk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign TX_EN    = tx_en_q;
    assign TX_DATA  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a behavioural 16x-oversampled 8N1 serializer.
`timescale 1ns/1ps
module tb_uart_tx_feeder;

    localparam int DL = 4;

    logic          BRclk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full, empty, overflow;
    logic [DL:0]   count;
    logic          TX_STATUS;
    logic          TX_EN;
    logic [7:0]    TX_DATA;

    int checks = 0;
    int errors = 0;

    uart_tx_feeder #(.DEPTH_LOG2(DL), .GAP_CYCLES(16)) dut (
        .BRclk(BRclk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .TX_STATUS(TX_STATUS), .TX_EN(TX_EN), .TX_DATA(TX_DATA)
    );

    always #5 BRclk = ~BRclk;

    // Serializer: start bit, 8 data bits LSB first, stop bit, 16 clocks per bit.
    logic       ser_busy, ser_line;
    logic [9:0] ser_frame;
    logic [3:0] ser_tick, ser_bit;
    assign TX_STATUS = ser_busy;

    always @(posedge BRclk) begin
        if (reset) begin
            ser_busy <= 1'b0; ser_line <= 1'b1; ser_tick <= 4'd0; ser_bit <= 4'd0; ser_frame <= 10'h3FF;
        end else if (!ser_busy) begin
            if (TX_EN) begin
                ser_busy  <= 1'b1;
                ser_frame <= {1'b1, TX_DATA, 1'b0};
                ser_line  <= 1'b0;
                ser_tick  <= 4'd0;
                ser_bit   <= 4'd0;
            end
        end else if (ser_tick == 4'd15) begin
            ser_tick <= 4'd0;
            if (ser_bit == 4'd9) begin
                ser_busy <= 1'b0;
                ser_line <= 1'b1;
            end else begin
                ser_bit  <= ser_bit + 4'd1;
                ser_line <= ser_frame[ser_bit + 4'd1];
            end
        end else begin
            ser_tick <= ser_tick + 4'd1;
        end
    end

    // Launch monitor: logs launched bytes and protocol violations.
    int         cyc = 0;
    int         fall_cyc = 0;
    int         log_n = 0;
    logic [7:0] log_data [256];
    int         log_gap [256];
    int         viol_overlap = 0, viol_pulse = 0, viol_hold = 0;
    logic       prev_en = 1'b0, prev_st = 1'b0;
    logic [7:0] held = 8'h00;

    always @(posedge BRclk) cyc <= cyc + 1;

    always @(negedge BRclk) begin
        if (reset) begin
            prev_en <= 1'b0;
            prev_st <= 1'b0;
        end else begin
            if (prev_st && !TX_STATUS) fall_cyc <= cyc;
            if (TX_EN) begin
                if (log_n < 256) begin
                    log_data[log_n] <= TX_DATA;
                    log_gap[log_n]  <= cyc - fall_cyc;
                end
                log_n <= log_n + 1;
                held  <= TX_DATA;
                if (TX_STATUS) viol_overlap <= viol_overlap + 1;
                if (prev_en)   viol_pulse   <= viol_pulse + 1;
            end
            if (TX_STATUS && TX_DATA !== held) viol_hold <= viol_hold + 1;
            prev_en <= TX_EN;
            prev_st <= TX_STATUS;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge BRclk);
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        @(negedge BRclk);
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_status(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (TX_STATUS !== lvl && n < budget) begin
            @(negedge BRclk);
            n++;
        end
        checks++;
        if (TX_STATUS !== lvl) begin
            errors++;
            $display("FAIL %s: TX_STATUS=%b after %0d cycles, required %b", tag, TX_STATUS, budget, lvl);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < budget) begin
            @(negedge BRclk);
            n++;
            if (empty && !TX_STATUS && !TX_EN) quiet++; else quiet = 0;
        end
        checks++;
        if (quiet < 4) begin
            errors++;
            $display("FAIL %s: not idle after %0d cycles, required idle", tag, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        tick(3);
        checks += 6;
        if (TX_EN !== 1'b0)      begin errors++; $display("FAIL rst_tx_en: got %b, expected 0", TX_EN); end
        if (TX_DATA !== 8'h00)   begin errors++; $display("FAIL rst_tx_data: got %h, expected 00", TX_DATA); end
        if (count !== 5'd0)      begin errors++; $display("FAIL rst_count: got %0d, expected 0", count); end
        if (empty !== 1'b1)      begin errors++; $display("FAIL rst_empty: got %b, expected 1", empty); end
        if (full !== 1'b0)       begin errors++; $display("FAIL rst_full: got %b, expected 0", full); end
        if (overflow !== 1'b0)   begin errors++; $display("FAIL rst_overflow: got %b, expected 0", overflow); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_single();
        logic [9:0] exp_line = 10'b1101001010;
        int base = log_n;
        push(8'hA5);
        checks += 2;
        if (count !== 5'd1) begin errors++; $display("FAIL single_count1: got %0d, expected 1", count); end
        if (empty !== 1'b0) begin errors++; $display("FAIL single_empty0: got %b, expected 0", empty); end
        tick(1);
        checks += 3;
        if (TX_EN !== 1'b1)    begin errors++; $display("FAIL single_latency: TX_EN got %b, expected 1", TX_EN); end
        if (TX_DATA !== 8'hA5) begin errors++; $display("FAIL single_data: got %h, expected a5", TX_DATA); end
        if (count !== 5'd0)    begin errors++; $display("FAIL single_pop: count got %0d, expected 0", count); end
        tick(1);
        checks++;
        if (TX_EN !== 1'b0) begin errors++; $display("FAIL single_pulse_width: TX_EN got %b, expected 0", TX_EN); end
        tick(8);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ser_line !== exp_line[i]) begin
                errors++; $display("FAIL single_line_bit%0d: got %b, expected %b", i, ser_line, exp_line[i]);
            end
            tick(16);
        end
        wait_idle(200, "single_idle");
        checks += 2;
        if (log_n - base !== 1) begin errors++; $display("FAIL single_frames: got %0d, expected 1", log_n - base); end
        if (count !== 5'd0)     begin errors++; $display("FAIL single_count_end: got %0d, expected 0", count); end
    endtask

    task automatic test_three();
        int base = log_n;
        int peak = 0;
        push(8'h01); if (int'(count) > peak) peak = int'(count);
        push(8'h02); if (int'(count) > peak) peak = int'(count);
        push(8'h03); if (int'(count) > peak) peak = int'(count);
        wait_idle(800, "three_idle");
        checks += 5;
        if (peak !== 2)            begin errors++; $display("FAIL three_peak: got %0d, expected 2", peak); end
        if (log_n - base !== 3)    begin errors++; $display("FAIL three_frames: got %0d, expected 3", log_n - base); end
        if (log_data[base] !== 8'h01)   begin errors++; $display("FAIL three_order0: got %h, expected 01", log_data[base]); end
        if (log_data[base+1] !== 8'h02) begin errors++; $display("FAIL three_order1: got %h, expected 02", log_data[base+1]); end
        if (log_data[base+2] !== 8'h03) begin errors++; $display("FAIL three_order2: got %h, expected 03", log_data[base+2]); end
    endtask

    task automatic test_overflow();
        int base = log_n;
        push(8'h10);
        wait_status(1'b1, 10, "ovf_busy");
        for (int i = 0; i < 17; i++) push(8'h20 + 8'(i));
        checks += 3;
        if (full !== 1'b1)     begin errors++; $display("FAIL ovf_full: got %b, expected 1", full); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
        if (count !== 5'd16)   begin errors++; $display("FAIL ovf_count: got %0d, expected 16", count); end
        wait_idle(17 * 170 + 100, "ovf_idle");
        checks += 3;
        if (log_n - base !== 17)      begin errors++; $display("FAIL ovf_frames: got %0d, expected 17", log_n - base); end
        if (log_data[base] !== 8'h10) begin errors++; $display("FAIL ovf_first: got %h, expected 10", log_data[base]); end
        if (overflow !== 1'b1)        begin errors++; $display("FAIL ovf_hold: got %b, expected 1", overflow); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (log_data[base+1+i] !== 8'h20 + 8'(i)) begin
                errors++; $display("FAIL ovf_order%0d: got %h, expected %h", i, log_data[base+1+i], 8'h20 + 8'(i));
            end
        end
    endtask

    task automatic test_launch_write();
        int base;
        do_reset();
        base = log_n;
        push(8'h40);
        wait_status(1'b1, 10, "lw_busy");
        for (int i = 0; i < 16; i++) push(8'h41 + 8'(i));
        checks += 2;
        if (count !== 5'd16)   begin errors++; $display("FAIL lw_count_full: got %0d, expected 16", count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL lw_no_ovf: got %b, expected 0", overflow); end
        wait_status(1'b0, 200, "lw_done");
        tick(1);
        push(8'h5A);
        checks += 4;
        if (TX_EN !== 1'b1)    begin errors++; $display("FAIL lw_launch: TX_EN got %b, expected 1", TX_EN); end
        if (count !== 5'd16)   begin errors++; $display("FAIL lw_count: got %0d, expected 16", count); end
        if (full !== 1'b1)     begin errors++; $display("FAIL lw_full: got %b, expected 1", full); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL lw_overflow: got %b, expected 0", overflow); end
        wait_idle(17 * 170 + 100, "lw_idle");
        checks += 3;
        if (log_n - base !== 18)         begin errors++; $display("FAIL lw_frames: got %0d, expected 18", log_n - base); end
        if (log_data[base+1] !== 8'h41)  begin errors++; $display("FAIL lw_second: got %h, expected 41", log_data[base+1]); end
        if (log_data[base+17] !== 8'h5A) begin errors++; $display("FAIL lw_last: got %h, expected 5a", log_data[base+17]); end
    endtask

    task automatic test_reset_mid();
        int n0;
        push(8'h60);
        wait_status(1'b1, 10, "rm_busy");
        for (int i = 0; i < 5; i++) push(8'h61 + 8'(i));
        tick(60);
        reset = 1'b1;
        tick(1);
        checks += 3;
        if (empty !== 1'b1) begin errors++; $display("FAIL rm_empty: got %b, expected 1", empty); end
        if (TX_EN !== 1'b0) begin errors++; $display("FAIL rm_tx_en: got %b, expected 0", TX_EN); end
        if (count !== 5'd0) begin errors++; $display("FAIL rm_count: got %0d, expected 0", count); end
        reset = 1'b0;
        n0 = log_n;
        tick(400);
        checks++;
        if (log_n !== n0) begin errors++; $display("FAIL rm_no_frames: got %0d launches, expected 0", log_n - n0); end
        push(8'h77);
        wait_idle(300, "rm_idle");
        checks += 2;
        if (log_n - n0 !== 1)       begin errors++; $display("FAIL rm_after_frames: got %0d, expected 1", log_n - n0); end
        if (log_data[n0] !== 8'h77) begin errors++; $display("FAIL rm_after_data: got %h, expected 77", log_data[n0]); end
    endtask

    task automatic test_back_to_back();
        int base = log_n;
        int g;
        push(8'h81);
        push(8'h82);
        wait_idle(600, "b2b_idle");
        g = log_gap[base+1];
        checks += 3;
        if (log_n - base !== 2)         begin errors++; $display("FAIL b2b_frames: got %0d, expected 2", log_n - base); end
        if (log_data[base+1] !== 8'h82) begin errors++; $display("FAIL b2b_data: got %h, expected 82", log_data[base+1]); end
`ifdef UART_TX_GAP_EN
        if (g < 17) begin errors++; $display("FAIL b2b_gap: got %0d cycles, expected >= 17", g); end
`else
        if (g < 1 || g > 2) begin errors++; $display("FAIL b2b_gap: got %0d cycles, expected 1..2", g); end
`endif
    endtask

    task automatic test_protocol();
        checks += 3;
        if (viol_overlap !== 0) begin errors++; $display("FAIL proto_overlap: got %0d, expected 0", viol_overlap); end
        if (viol_pulse !== 0)   begin errors++; $display("FAIL proto_pulse: got %0d, expected 0", viol_pulse); end
        if (viol_hold !== 0)    begin errors++; $display("FAIL proto_hold: got %0d, expected 0", viol_hold); end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        @(negedge BRclk);
        test_reset();
        test_single();
        test_three();
        test_overflow();
        test_launch_write();
        test_reset_mid();
        test_back_to_back();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
